scoreboard_ctrl: RTL and testbench
==================================

# scoreboard_ctrl

Score-keeping stage feeding the 4-digit seven-segment display multiplexer. It debounces five push-buttons, keeps two saturating 2-digit BCD team scores, and produces the packed digit word, decimal-point mask, blanking mask and 2-bit scan index the display stage consumes. It is the only sequential producer of display data in the scoreboard design.

## Interface
- DEB_CYCLES, 20'd500000 — consecutive stable cycles required before a button level is accepted (≥2)
- SCAN_DIV, 16 — scan prescaler width; Scan advances every 2^SCAN_DIV cycles
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- btn_a_inc  in  1  raw button, team A +1 (asynchronous, bouncing, active-high)
- btn_a_dec  in  1  raw button, team A −1
- btn_b_inc  in  1  raw button, team B +1
- btn_b_dec  in  1  raw button, team B −1
- btn_clr  in  1  raw button, clear both scores
- Hexs  out  16  {A tens, A ones, B tens, B ones}, one BCD nibble each, [15:12] is leftmost digit
- point  out  4  decimal-point enable per digit, bit i ↔ digit i, 1 = lit
- LES  out  4  blanking per digit, bit i ↔ digit i, 1 = blank
- Scan  out  2  current digit index for the display multiplexer

## Operation
- Per button: 2-FF synchronizer → debouncer → rising-edge detector giving a one-cycle pulse.
- Debouncer: holds accepted level `deb` (reset 0) and counter `cnt` (reset 0). Each cycle: if synced level == deb, cnt ← 0; else cnt ← cnt+1, and when cnt == DEB_CYCLES−1 set deb ← synced level, cnt ← 0. Any single cycle of agreement restarts the count (bounce rejection).
- Pulse = deb & ~deb_d (deb_d is deb delayed one cycle); one pulse per accepted press, none on release.
- Score update per team, registered, evaluated in priority order:
  - clr pulse: both scores ← 00.
  - inc and dec pulses same cycle for same team: no change.
  - inc: BCD +1; ones 9 → 0 with tens +1; 99 saturates at 99.
  - dec: BCD −1; ones 0 → 9 with tens −1; 00 saturates at 00.
  - Teams update independently in the same cycle.
- Digits never hold values A–F.
- point fixed at 4'b0100 (dot after A ones, separating teams).
- LES registered, updated on the same edge as Hexs: LES[3] = (A tens == 0), LES[1] = (B tens == 0), LES[2] = LES[0] = 0 (ones always shown).
- Scan: free-running counter of width SCAN_DIV+2; Scan = top two bits; sequence 0,1,2,3,0…; independent of buttons.

## Timing
- Reset (async assert, sync release): Hexs = 16'h0000, point = 4'b0100, LES = 4'b1010, Scan = 2'b00; all synchronizers, debounce counters, deb and deb_d = 0.
- Press latency: a raw level change first sampled at edge E and held steady changes deb at edge E+1+DEB_CYCLES, pulse is high during the following cycle, and Hexs/LES update at edge E+2+DEB_CYCLES.
- Held button: exactly one update, regardless of duration.
- Reset mid-debounce or mid-press: count discarded; a button still held after release of rst_n is re-debounced and produces one pulse.
- Scan period: 2^SCAN_DIV cycles per index, 2^(SCAN_DIV+2) per full frame; wraps 3 → 0 without glitch.
- Outputs are all register-driven; no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_n = 0 mid-run → Hexs = 0000, LES = 1010, point = 0100, Scan = 0 immediately (asynchronous).
- Debounce (DEB_CYCLES = 4): btn_a_inc high for 3 cycles, low 1, high 10 → exactly one increment, Hexs = 16'h0100, update at the computed E+2+DEB_CYCLES edge; 3-cycle glitch alone → no change.
- BCD carry and saturation: 9 presses of A inc → Hexs[15:8] = 09, LES[3] = 1; 10th → 10, LES[3] = 0; preload to 99, press inc → stays 99; B dec at 00 → stays 00; B at 10, dec → 09.
- Simultaneous events: A inc and A dec accepted in same cycle → A unchanged; A inc with B dec same cycle → both apply; clr with any inc → 0000.
- Scan (SCAN_DIV = 2): Scan steps every 4 cycles through 0,1,2,3,0 with no skipped or repeated index across 3 frames.

Source files
------------

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: debounces five score buttons, keeps two saturating BCD
// team scores and drives the digit, point, blanking and scan outputs.
`default_nettype none

module scoreboard_ctrl #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000,
  parameter int          SCAN_DIV   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_a_inc,
  input  logic        btn_a_dec,
  input  logic        btn_b_inc,
  input  logic        btn_b_dec,
  input  logic        btn_clr,
  output logic [15:0] Hexs,
  output logic [3:0]  point,
  output logic [3:0]  LES,
  output logic [1:0]  Scan
);

  localparam int BTN_N = 5;

  logic [BTN_N-1:0] btn_raw;
  logic [BTN_N-1:0] pulse;

  assign btn_raw = {btn_clr, btn_b_dec, btn_b_inc, btn_a_dec, btn_a_inc};

  generate
    for (genvar i = 0; i < BTN_N; i++) begin : g_btn
      logic        sync1;
      logic        sync2;
      logic        deb;
      logic        deb_d;
      logic [19:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
          deb   <= 1'b0;
          deb_d <= 1'b0;
          cnt   <= '0;
        end else begin
          sync1 <= btn_raw[i];
          sync2 <= sync1;
          deb_d <= deb;
          // a single cycle of agreement restarts the stability count
          if (sync2 == deb) begin
            cnt <= '0;
          end else if (cnt == DEB_CYCLES - 20'd1) begin
            deb <= sync2;
            cnt <= '0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
      end

      assign pulse[i] = deb & ~deb_d;
    end
  endgenerate

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)            return v;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)            return v;
    else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    else                       return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [7:0] score_a, score_b;
  logic [7:0] score_a_nxt, score_b_nxt;

  always_comb begin
    score_a_nxt = score_a;
    score_b_nxt = score_b;
    if (pulse[4]) begin
      score_a_nxt = 8'h00;
      score_b_nxt = 8'h00;
    end else begin
      if (pulse[0] && !pulse[1])      score_a_nxt = bcd_inc(score_a);
      else if (pulse[1] && !pulse[0]) score_a_nxt = bcd_dec(score_a);
      if (pulse[2] && !pulse[3])      score_b_nxt = bcd_inc(score_b);
      else if (pulse[3] && !pulse[2]) score_b_nxt = bcd_dec(score_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_a <= 8'h00;
      score_b <= 8'h00;
      LES     <= 4'b1010;
    end else begin
      score_a <= score_a_nxt;
      score_b <= score_b_nxt;
      // blanking tracks the new tens digits so it lands with the scores
      LES     <= {score_a_nxt[7:4] == 4'd0, 1'b0, score_b_nxt[7:4] == 4'd0, 1'b0};
    end
  end

  logic [SCAN_DIV+1:0] scan_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_cnt <= '0;
    else        scan_cnt <= scan_cnt + {{(SCAN_DIV+1){1'b0}}, 1'b1};
  end

  assign Hexs  = {score_a, score_b};
  assign point = 4'b0100;
  assign Scan  = scan_cnt[SCAN_DIV+1:SCAN_DIV];

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_ctrl.sv
// tb_scoreboard_ctrl: directed checks of debounce, BCD scoring, reset and scan.
`default_nettype none

module tb_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btns = 5'b0;   // {clr, b_dec, b_inc, a_dec, a_inc}
  logic [15:0] Hexs;
  logic [3:0]  point;
  logic [3:0]  LES;
  logic [1:0]  Scan;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scoreboard_ctrl #(.DEB_CYCLES(20'd4), .SCAN_DIV(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_a_inc (btns[0]),
    .btn_a_dec (btns[1]),
    .btn_b_inc (btns[2]),
    .btn_b_dec (btns[3]),
    .btn_clr   (btns[4]),
    .Hexs      (Hexs),
    .point     (point),
    .LES       (LES),
    .Scan      (Scan)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    btns = m;
    repeat (hold) @(negedge clk);
    btns = 5'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_hexs",  Hexs, 16'h0000);
    check("reset_point", {12'h0, point}, 16'h0004);
    check("reset_les",   {12'h0, LES}, 16'h000A);
    check("reset_scan",  {14'h0, Scan}, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // lone 3-cycle glitch is rejected
    press(5'b00001, 3);
    repeat (4) @(negedge clk);
    check("glitch_only", Hexs, 16'h0000);

    // high 3, low 1, high 10: one increment, at E+6 of the final rise
    btns = 5'b00001;
    repeat (3) @(negedge clk);
    btns = 5'b00000;
    @(negedge clk);
    btns = 5'b00001;
    repeat (6) @(negedge clk);
    check("latency_before", Hexs, 16'h0000);
    @(negedge clk);
    check("latency_at", Hexs, 16'h0100);
    repeat (3) @(negedge clk);
    btns = 5'b0;
    repeat (8) @(negedge clk);

    repeat (8) press(5'b00001, 8);
    check("a_09", Hexs, 16'h0900);
    check("a_09_les", {12'h0, LES}, 16'h000A);
    press(5'b00001, 8);
    check("a_10", Hexs, 16'h1000);
    check("a_10_les", {12'h0, LES}, 16'h0002);
    repeat (89) press(5'b00001, 8);
    check("a_99", Hexs, 16'h9900);
    press(5'b00001, 8);
    check("a_sat99", Hexs, 16'h9900);
    press(5'b00010, 8);
    check("a_dec98", Hexs, 16'h9800);

    press(5'b01000, 8);
    check("b_sat00", Hexs, 16'h9800);
    check("b_sat00_les", {12'h0, LES}, 16'h0002);
    repeat (10) press(5'b00100, 8);
    check("b_10", Hexs, 16'h9810);
    check("b_10_les", {12'h0, LES}, 16'h0000);
    press(5'b01000, 8);
    check("b_dec09", Hexs, 16'h9809);
    check("b_09_les", {12'h0, LES}, 16'h0002);

    press(5'b00011, 8);
    check("a_inc_dec", Hexs, 16'h9809);
    press(5'b01001, 8);
    check("a_inc_b_dec", Hexs, 16'h9908);
    press(5'b10001, 8);
    check("clr_inc", Hexs, 16'h0000);
    check("clr_les", {12'h0, LES}, 16'h000A);

    press(5'b00001, 40);
    check("held_once", Hexs, 16'h0100);

    // asynchronous reset in the middle of a press, button still held after
    btns = 5'b00001;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_hexs",  Hexs, 16'h0000);
    check("async_les",   {12'h0, LES}, 16'h000A);
    check("async_point", {12'h0, point}, 16'h0004);
    check("async_scan",  {14'h0, Scan}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("redebounce", Hexs, 16'h0100);
    btns = 5'b0;
    repeat (8) @(negedge clk);

    // scan sequence from a fresh reset release
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 48; i++) begin
      check("scan_seq", {14'h0, Scan}, 16'((i / 4) % 4));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
